// File: rtl/rv_index_pool_if.sv
// Acquire/release handshake bundle for the index pool.
// The master side requests slots and returns them; the slave side is the pool.
interface rv_index_pool_if #(
  parameter int DATAW   = 8,
  parameter int ADDRW   = 3,
  parameter int NUM_REL = 2
);
  logic                     acq_valid;
  logic                     acq_ready;
  logic [DATAW-1:0]         acq_data;
  logic [ADDRW-1:0]         acq_idx;
  logic [NUM_REL-1:0]       rel_valid;
  logic [NUM_REL*ADDRW-1:0] rel_idx;

  modport master (
    output acq_valid, acq_data, rel_valid, rel_idx,
    input  acq_ready, acq_idx
  );

  modport slave (
    input  acq_valid, acq_data, rel_valid, rel_idx,
    output acq_ready, acq_idx
  );
endinterface

// File: rtl/rv_index_pool.sv
// Slot-index allocator with per-slot payload storage.
// Hands out the lowest free index, accepts releases on several ports at once,
// keeps an occupancy count and flags releases of slots that are already free.
module rv_index_pool #(
  parameter int DATAW   = 8,
  parameter int SIZE    = 8,
  parameter int ADDRW   = $clog2(SIZE),
  parameter int NUM_REL = 2,
  parameter int CNTW    = $clog2(SIZE + 1)
) (
  input  logic             clk,
  input  logic             reset,
  rv_index_pool_if.slave   pool,
  input  logic [ADDRW-1:0] rd_idx,
  output logic [DATAW-1:0] rd_data,
  output logic             rd_busy,
  output logic [CNTW-1:0]  count,
  output logic             empty,
  output logic             full,
  output logic             err_double_free
);

  logic [SIZE-1:0]  free_r;
  logic [SIZE-1:0]  free_n;
  logic [CNTW-1:0]  count_r;
  logic [CNTW-1:0]  count_n;
  logic             empty_r;
  logic             full_r;
  logic             err_r;
  logic [ADDRW-1:0] acq_idx_r;
  logic [ADDRW-1:0] acq_idx_n;
  logic             idx_found;
  logic [DATAW-1:0] rd_data_r;
  logic             rd_busy_r;

  logic             acq_fire;
  logic [SIZE-1:0]  acq_mask;
  logic [SIZE-1:0]  rel_req;
  logic [SIZE-1:0]  rel_ok;
  logic             dbl_free;
  logic [CNTW-1:0]  rel_cnt;

  logic [DATAW-1:0] ram [SIZE];

  // acq_ready comes purely from registered state so acq_valid never loops back
  assign acq_fire       = pool.acq_valid & ~full_r;
  assign pool.acq_ready = ~full_r;
  assign pool.acq_idx   = acq_idx_r;

  // Merge all release ports into one mask; a slot already free is a double free
  always_comb begin
    rel_req  = '0;
    dbl_free = 1'b0;
    for (int p = 0; p < NUM_REL; p++) begin
      if (pool.rel_valid[p]) begin
        rel_req[pool.rel_idx[p*ADDRW +: ADDRW]] = 1'b1;
        if (free_r[pool.rel_idx[p*ADDRW +: ADDRW]]) begin
          dbl_free = 1'b1;
        end
      end
    end
  end

  // Next free mask, occupancy and lowest-free index for the coming cycle
  always_comb begin
    acq_mask = '0;
    if (acq_fire) begin
      acq_mask[acq_idx_r] = 1'b1;
    end
    rel_ok = rel_req & ~free_r;
    free_n = (free_r | rel_ok) & ~acq_mask;

    rel_cnt = '0;
    for (int i = 0; i < SIZE; i++) begin
      rel_cnt = rel_cnt + CNTW'(rel_ok[i]);
    end
    count_n = count_r + CNTW'(acq_fire) - rel_cnt;

    acq_idx_n = acq_idx_r;
    idx_found = 1'b0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (free_n[i]) begin
        acq_idx_n = ADDRW'(i);
        idx_found = 1'b1;
      end
    end
  end

  // Pool bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      free_r    <= '1;
      count_r   <= '0;
      empty_r   <= 1'b1;
      full_r    <= 1'b0;
      err_r     <= 1'b0;
      acq_idx_r <= '0;
    end else begin
      free_r  <= free_n;
      count_r <= count_n;
      empty_r <= (count_n == '0);
      full_r  <= (count_n == CNTW'(SIZE));
      err_r   <= err_r | dbl_free;
      if (idx_found) begin
        acq_idx_r <= acq_idx_n;
      end
    end
  end

  // Payload storage, written on every accepted acquire and never reset
  always_ff @(posedge clk) begin
    if (acq_fire) begin
      ram[acq_idx_r] <= pool.acq_data;
    end
  end

  // Registered read port; an acquire of the same slot this cycle is forwarded
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r <= '0;
      rd_busy_r <= 1'b0;
    end else if (acq_fire && (rd_idx == acq_idx_r)) begin
      rd_data_r <= pool.acq_data;
      rd_busy_r <= 1'b1;
    end else begin
      rd_data_r <= ram[rd_idx];
      rd_busy_r <= ~free_r[rd_idx];
    end
  end

  assign rd_data         = rd_data_r;
  assign rd_busy         = rd_busy_r;
  assign count           = count_r;
  assign empty           = empty_r;
  assign full            = full_r;
  assign err_double_free = err_r;

endmodule

// File: tb/tb_rv_index_pool.sv
// Directed bench for rv_index_pool: fill, release, double free, read forwarding, reset.
module tb_rv_index_pool;
  localparam int DATAW   = 8;
  localparam int SIZE    = 8;
  localparam int ADDRW   = 3;
  localparam int NUM_REL = 2;
  localparam int CNTW    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [ADDRW-1:0] rd_idx;
  logic [DATAW-1:0] rd_data;
  logic             rd_busy;
  logic [CNTW-1:0]  count;
  logic             empty;
  logic             full;
  logic             err_double_free;

  int tests_run    = 0;
  int tests_failed = 0;

  rv_index_pool_if #(.DATAW(DATAW), .ADDRW(ADDRW), .NUM_REL(NUM_REL)) pool_if ();

  rv_index_pool #(
    .DATAW(DATAW), .SIZE(SIZE), .ADDRW(ADDRW), .NUM_REL(NUM_REL), .CNTW(CNTW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pool(pool_if),
    .rd_idx(rd_idx),
    .rd_data(rd_data),
    .rd_busy(rd_busy),
    .count(count),
    .empty(empty),
    .full(full),
    .err_double_free(err_double_free)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample 1ns after the rising edge
  task automatic applyStimulus(input logic av, input logic [7:0] ad,
                               input logic [1:0] rv, input logic [2:0] r0, input logic [2:0] r1,
                               input logic [2:0] ri);
    pool_if.acq_valid = av;
    pool_if.acq_data  = ad;
    pool_if.rel_valid = rv;
    pool_if.rel_idx   = {r1, r0};
    rd_idx            = ri;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 2'b00, 3'd0, 3'd0, 3'd0);
    applyStimulus(1'b0, 8'h00, 2'b00, 3'd0, 3'd0, 3'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_ready", 32'(pool_if.acq_ready), 32'd1);
    checkOutput("rst_idx", 32'(pool_if.acq_idx), 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("rst_rd_busy", 32'(rd_busy), 32'd0);
    checkOutput("rst_err", 32'(err_double_free), 32'd0);
    reset = 1'b0;

    // Fill the pool: indices handed out 0..7 in order
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("fill_idx%0d", i), 32'(pool_if.acq_idx), 32'(i));
      applyStimulus(1'b1, 8'(8'hA0 + i), 2'b00, 3'd0, 3'd0, 3'd0);
    end
    checkOutput("fill_count", 32'(count), 32'd8);
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_ready", 32'(pool_if.acq_ready), 32'd0);
    checkOutput("fill_empty", 32'(empty), 32'd0);

    // Ninth request is ignored; read slot 2 meanwhile
    applyStimulus(1'b1, 8'hEE, 2'b00, 3'd0, 3'd0, 3'd2);
    checkOutput("ovf_count", 32'(count), 32'd8);
    checkOutput("ovf_err", 32'(err_double_free), 32'd0);
    checkOutput("rd2_data", 32'(rd_data), 32'hA2);
    checkOutput("rd2_busy", 32'(rd_busy), 32'd1);
    applyStimulus(1'b0, 8'h00, 2'b00, 3'd0, 3'd0, 3'd7);
    checkOutput("rd7_data", 32'(rd_data), 32'hA7);

    // Release 3 and 5 together
    applyStimulus(1'b0, 8'h00, 2'b11, 3'd3, 3'd5, 3'd0);
    checkOutput("rel35_count", 32'(count), 32'd6);
    checkOutput("rel35_full", 32'(full), 32'd0);
    checkOutput("rel35_idx", 32'(pool_if.acq_idx), 32'd3);
    applyStimulus(1'b1, 8'h33, 2'b00, 3'd0, 3'd0, 3'd0);
    checkOutput("acq3_idx", 32'(pool_if.acq_idx), 32'd5);
    checkOutput("acq3_count", 32'(count), 32'd7);
    applyStimulus(1'b1, 8'h55, 2'b00, 3'd0, 3'd0, 3'd0);
    checkOutput("acq5_count", 32'(count), 32'd8);
    checkOutput("acq5_full", 32'(full), 32'd1);

    // Both ports release 2 at once: single release, no error
    applyStimulus(1'b0, 8'h00, 2'b11, 3'd2, 3'd2, 3'd0);
    checkOutput("dup2_count", 32'(count), 32'd7);
    checkOutput("dup2_err", 32'(err_double_free), 32'd0);
    checkOutput("dup2_idx", 32'(pool_if.acq_idx), 32'd2);

    // Release 6 legitimately, then again while free
    applyStimulus(1'b0, 8'h00, 2'b01, 3'd6, 3'd0, 3'd0);
    checkOutput("rel6_count", 32'(count), 32'd6);
    checkOutput("rel6_err", 32'(err_double_free), 32'd0);
    applyStimulus(1'b0, 8'h00, 2'b10, 3'd0, 3'd6, 3'd0);
    checkOutput("dbl6_count", 32'(count), 32'd6);
    checkOutput("dbl6_err", 32'(err_double_free), 32'd1);
    applyStimulus(1'b0, 8'h00, 2'b00, 3'd0, 3'd0, 3'd0);
    checkOutput("sticky_err", 32'(err_double_free), 32'd1);

    // Free 4, take 2, then take 4 while reading 4 (write-first forwarding)
    applyStimulus(1'b0, 8'h00, 2'b01, 3'd4, 3'd0, 3'd0);
    checkOutput("rel4_count", 32'(count), 32'd5);
    applyStimulus(1'b1, 8'h22, 2'b00, 3'd0, 3'd0, 3'd4);
    checkOutput("acq2_idx", 32'(pool_if.acq_idx), 32'd4);
    checkOutput("rd4_free_busy", 32'(rd_busy), 32'd0);
    applyStimulus(1'b1, 8'h5C, 2'b00, 3'd0, 3'd0, 3'd4);
    checkOutput("fwd_data", 32'(rd_data), 32'h5C);
    checkOutput("fwd_busy", 32'(rd_busy), 32'd1);
    checkOutput("fwd_count", 32'(count), 32'd7);
    checkOutput("fwd_idx", 32'(pool_if.acq_idx), 32'd6);

    // Release 4 (read still sees it busy this cycle), then read again
    applyStimulus(1'b0, 8'h00, 2'b01, 3'd4, 3'd0, 3'd4);
    checkOutput("rel4b_busy", 32'(rd_busy), 32'd1);
    applyStimulus(1'b0, 8'h00, 2'b00, 3'd0, 3'd0, 3'd4);
    checkOutput("rd4_after_rel", 32'(rd_busy), 32'd0);
    checkOutput("rd4_data_kept", 32'(rd_data), 32'h5C);

    // Release 1 to reach count 5, then reset mid-operation
    applyStimulus(1'b0, 8'h00, 2'b10, 3'd0, 3'd1, 3'd4);
    checkOutput("pre_rst_count", 32'(count), 32'd5);
    checkOutput("pre_rst_idx", 32'(pool_if.acq_idx), 32'd1);
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 2'b00, 3'd0, 3'd0, 3'd4);
    reset = 1'b0;
    checkOutput("mid_rst_count", 32'(count), 32'd0);
    checkOutput("mid_rst_empty", 32'(empty), 32'd1);
    checkOutput("mid_rst_idx", 32'(pool_if.acq_idx), 32'd0);
    checkOutput("mid_rst_err", 32'(err_double_free), 32'd0);
    checkOutput("mid_rst_rd_data", 32'(rd_data), 32'd0);

    // Acquire 0, then acquire 1 while also releasing 1: acquire wins, error flagged
    applyStimulus(1'b1, 8'h10, 2'b00, 3'd0, 3'd0, 3'd0);
    checkOutput("post_rst_idx", 32'(pool_if.acq_idx), 32'd1);
    applyStimulus(1'b1, 8'h11, 2'b01, 3'd1, 3'd0, 3'd0);
    checkOutput("acqrel_count", 32'(count), 32'd2);
    checkOutput("acqrel_err", 32'(err_double_free), 32'd1);
    checkOutput("acqrel_idx", 32'(pool_if.acq_idx), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
